// File: rtl/texture_load_arbiter.sv
// Arbitrates the single texture-memory port between renderer reads (always win) and a byte-stream loader.
// Optional: define TEXTURE_LOAD_CHECKSUM_EN to add the 8-bit load_checksum output.
module texture_load_arbiter #(
  parameter int CHANNEL_BITS = 2,
  parameter int ADDR_BITS    = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic [7:0]                load_data,
  output logic                      load_ready,
  output logic                      load_busy,
  output logic                      load_done,
  input  logic                      rd_req,
  input  logic                      side,
  input  logic [5:0]                col,
  input  logic [5:0]                row,
  output logic                      rd_valid,
  output logic [CHANNEL_BITS*3-1:0] rd_val,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic                      mem_we,
  output logic [CHANNEL_BITS*3-1:0] mem_wdata,
  input  logic [CHANNEL_BITS*3-1:0] mem_rdata
`ifdef TEXTURE_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]                load_checksum
`endif
);

  localparam int TW = CHANNEL_BITS * 3;

  // Loader handshake: a byte moves when load_valid && load_ready; load_ready is
  // derived only from flops (LOAD state and an empty skid buffer).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic                buf_full_q, buf_full_d;
  logic [TW-1:0]       buf_q, buf_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [TW-1:0]       rd_hold_q, rd_hold_d;

  logic accept;
  logic wr_grant;
  logic last_addr;

  // A pending write is dropped in the cycle load_start restarts the load.
  assign accept    = load_valid && load_ready;
  assign wr_grant  = (state_q == ST_LOAD) && buf_full_q && !rd_req && !load_start;
  assign last_addr = (waddr_q == {ADDR_BITS{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (load_start) state_d = ST_LOAD;
        else if (wr_grant && last_addr) state_d = ST_DONE;
      end
      ST_DONE: state_d = load_start ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_LOAD) && !buf_full_q;
    load_busy  = (state_q == ST_LOAD);
    load_done  = (state_q == ST_DONE);
    mem_we     = wr_grant;
    mem_wdata  = buf_q;
    if (rd_req) mem_addr = ADDR_BITS'({side, col, row});
    else if (wr_grant) mem_addr = waddr_q;
    else mem_addr = mem_addr_q;
    rd_valid = rd_valid_q;
    rd_val   = rd_valid_q ? mem_rdata : rd_hold_q;
  end

  // Accept and write never coincide: accept needs an empty buffer, write a full one.
  always_comb begin
    waddr_d    = waddr_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (load_start) begin
      waddr_d    = '0;
      buf_full_d = 1'b0;
    end else begin
      if (wr_grant) begin
        buf_full_d = 1'b0;
        if (!last_addr) waddr_d = waddr_q + ADDR_BITS'(1);
      end
      if (accept) begin
        buf_full_d = 1'b1;
        buf_d      = load_data[TW-1:0];
      end
    end
    mem_addr_d = mem_addr;
    rd_valid_d = rd_req;
    rd_hold_d  = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q    <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      mem_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      waddr_q    <= waddr_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      mem_addr_q <= mem_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

`ifdef TEXTURE_LOAD_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (load_start) cksum_d = '0;
    else if (accept) cksum_d = cksum_q + load_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cksum_q <= '0;
    else cksum_q <= cksum_d;
  end

  assign load_checksum = cksum_q;
`else
  logic unused_load_bits;
  assign unused_load_bits = ^load_data[7:TW];
`endif

endmodule

// File: tb/tb_texture_load_arbiter.sv
// Randomized bench for texture_load_arbiter: a scoreboard of expected writes and a texel
// reference memory, both built from the loading/arbitration rules.
module tb_texture_load_arbiter;

  localparam int AW    = 13;
  localparam int TW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = 40000;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = 8'h00;
  logic          load_ready, load_busy, load_done;
  logic          rd_req = 1'b0;
  logic          side = 1'b0;
  logic [5:0]    col = 6'd0;
  logic [5:0]    row = 6'd0;
  logic          rd_valid;
  logic [TW-1:0] rd_val;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [TW-1:0] mem_wdata;
  logic [TW-1:0] mem_rdata;
`ifdef TEXTURE_LOAD_CHECKSUM_EN
  logic [7:0]    load_checksum;
`endif

  texture_load_arbiter #(.CHANNEL_BITS(2), .ADDR_BITS(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .rd_req(rd_req), .side(side), .col(col), .row(row),
    .rd_valid(rd_valid), .rd_val(rd_val),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef TEXTURE_LOAD_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  // synchronous single-port texture memory
  logic [TW-1:0] tex_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) tex_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tex_mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard / reference model
  logic [18:0]   exp_q[$];
  logic [TW-1:0] ref_mem [DEPTH];
  bit            ref_known [DEPTH];
  int            n_acc = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  bit            busy_m = 0;
  bit            done_m = 0;
  bit            prev_rd = 0;
  logic [AW-1:0] prev_raddr = '0;
  logic [TW-1:0] hold_m = '0;
  bit            hold_known = 1;
  logic [7:0]    cksum_m = 8'h00;
  bit            prio_done = 0;

  always @(negedge clk) begin : monitor
    logic [AW-1:0] raddr;
    logic [18:0]   e;
    bit            exp_we, empty_pre, fin;
    if (!reset_n) begin
      exp_q.delete();
      busy_m = 0; done_m = 0; n_acc = 0; prev_rd = 0;
      hold_m = '0; hold_known = 1; cksum_m = 8'h00;
    end else begin
      raddr     = {side, col, row};
      empty_pre = (exp_q.size() == 0);
      exp_we    = !rd_req && !empty_pre && !load_start;
      fin       = 0;
      check("mem_we", mem_we, exp_we);
      check("load_ready", load_ready, busy_m && empty_pre);
      check("load_busy", load_busy, busy_m);
      check("load_done", load_done, done_m);
      check("rd_valid", rd_valid, prev_rd);
      if (rd_req) check("rd_addr", mem_addr, raddr);
      if (rd_valid) begin
        if (ref_known[prev_raddr]) begin
          check("rd_val", rd_val, ref_mem[prev_raddr]);
          hold_m = ref_mem[prev_raddr];
          hold_known = 1;
        end else begin
          hold_known = 0;
        end
      end else if (hold_known) begin
        check("rd_hold", rd_val, hold_m);
      end
      if (exp_we) begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[18:6]);
        check("wr_data", mem_wdata, e[5:0]);
        ref_mem[e[18:6]] = e[5:0];
        ref_known[e[18:6]] = 1;
        wr_cnt++;
        fin = (e[18:6] == AW'(DEPTH - 1));
      end
      if (done_m) begin
        done_cnt++;
`ifdef TEXTURE_LOAD_CHECKSUM_EN
        check("checksum", load_checksum, cksum_m);
`endif
      end
      done_m = fin;
      if (fin) busy_m = 0;
      if (load_valid && busy_m && empty_pre && !load_start) begin
        exp_q.push_back({n_acc[AW-1:0], load_data[TW-1:0]});
        n_acc++;
        cksum_m = cksum_m + load_data;
      end
      if (load_start) begin
        busy_m = 1; done_m = 0; n_acc = 0; cksum_m = 8'h00;
        exp_q.delete();
      end
      prev_rd = rd_req;
      prev_raddr = raddr;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_for(input int mode, input int idx);
    case (mode)
      0: return idx[7:0];
      1: return 8'hFF;
      2: return 8'h01;
      3: return (idx == 0) ? 8'h03 : 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_load_busy"}, load_busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_rd_val"}, rd_val, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic prio_burst();
    logic [AW-1:0] held;
    held = AW'(n_acc - 1);
    for (int i = 0; i < 10; i++) begin
      rd_req = 1; side = 1; col = 6'd5; row = 6'd9; load_valid = 1;
      @(negedge clk);
      check("prio_we", mem_we, 0);
      check("prio_addr", mem_addr, 13'h1149);
      if (i > 0) check("prio_rd_valid", rd_valid, 1);
      step();
    end
    rd_req = 0; load_valid = 0;
    @(negedge clk);
    check("prio_rd_valid_last", rd_valid, 1);
    check("prio_release_we", mem_we, 1);
    check("prio_release_addr", mem_addr, held);
    step();
  endtask

  // Starts at posedge+1; a full load runs until load_done, a partial one until nbytes are accepted.
  task automatic run_load(input int mode, input int nbytes, input int rd_pct, input bit prio);
    int budget;
    int done0;
    bit going;
    budget = 0; done0 = done_cnt; going = 1;
    load_start = 1; load_valid = 0; rd_req = 0;
    step();
    load_start = 0;
    while (going && budget < LIMIT) begin
      if (prio && !prio_done && n_acc >= 300 && exp_q.size() > 0) begin
        prio_done = 1;
        prio_burst();
      end
      load_valid = (rd_pct == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      load_data  = byte_for(mode, n_acc);
      rd_req     = ($urandom_range(0, 99) < rd_pct);
      {side, col, row} = 13'($urandom_range(0, DEPTH - 1));
      step();
      budget++;
      going = (nbytes < DEPTH) ? (n_acc < nbytes) : (done_cnt == done0);
    end
    load_valid = 0; rd_req = 0;
    check("load_in_budget", budget < LIMIT, 1);
  endtask

  initial begin : watchdog
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wr0, dc0;
    #13;
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset_n = 1;

    for (int i = 0; i < 10; i++) begin
      load_valid = 1; load_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("no_start_ready", load_ready, 0);
      step();
    end
    load_valid = 0;

    // partial load, then restart while a byte sits in the skid buffer
    run_load(4, 100, 20, 0);
    check("restart_buf_full", exp_q.size() > 0, 1);
    wr0 = wr_cnt; dc0 = done_cnt;
    run_load(0, DEPTH, 10, 1);
    check("full_load_writes", wr_cnt - wr0, DEPTH);
    check("prio_ran", prio_done, 1);
`ifdef TEXTURE_LOAD_CHECKSUM_EN
    check("cksum_addr_bytes", load_checksum, 8'h00);
`endif
    for (int i = 0; i < 5; i++) step();
    check("done_pulses", done_cnt - dc0, 1);

    rd_req = 1; side = 0; col = 6'd2; row = 6'd3;
    step();
    rd_req = 0;
    @(negedge clk);
    check("read131_valid", rd_valid, 1);
    check("read131_val", rd_val, 6'h03);
    step();
    for (int i = 0; i < 200; i++) begin
      rd_req = ($urandom_range(0, 99) < 60);
      {side, col, row} = 13'($urandom_range(0, DEPTH - 1));
      step();
    end
    rd_req = 0;
    step();

    // asynchronous reset in the middle of a load
    dc0 = done_cnt;
    run_load(4, 50, 20, 0);
    #2 reset_n = 0;
    #1 check_reset_outputs("async");
    step();
    step();
    reset_n = 1;
    for (int i = 0; i < 20; i++) step();
    check("no_done_after_abort", done_cnt - dc0, 0);

`ifdef TEXTURE_LOAD_CHECKSUM_EN
    run_load(1, DEPTH, 0, 0);
    check("cksum_all_ff", load_checksum, 8'h00);
    step();
    run_load(2, DEPTH, 0, 0);
    check("cksum_all_01", load_checksum, 8'h00);
    step();
    run_load(3, DEPTH, 0, 0);
    check("cksum_single_03", load_checksum, 8'h03);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/texture_load_arbiter.md
Name: texture_load_arbiter

Overview:
Owns the single port of the texture memory (128 columns x 64 rows of wall texels, addressed {side,col,row}) and shares it between two requesters.
- The renderer's texel reads always win.
- A byte-stream loader fills the memory sequentially at startup or on demand, with its writes stalled whenever the renderer is reading.
- Replaces sim-side population of texture data with a synthesisable load path.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; texel width is CHANNEL_BITS*3.
- ADDR_BITS, 13, memory address width ({side,col[5:0],row[5:0]}); depth = 2**ADDR_BITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse: begin a full reload from address 0.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte; low CHANNEL_BITS*3 bits are stored.
- load_ready  out  1  arbiter can accept load_data this cycle.
- load_busy  out  1  high while in LOAD state.
- load_done  out  1  one-cycle pulse when the last address is written.
- rd_req  in  1  renderer read request (level, one texel per cycle).
- side  in  1  texel address: wall side.
- col  in  6  texel address: column.
- row  in  6  texel address: row.
- rd_valid  out  1  rd_val holds the data for the request granted last cycle.
- rd_val  out  CHANNEL_BITS*3  texel data.
- mem_addr  out  ADDR_BITS  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  CHANNEL_BITS*3  memory write data.
- mem_rdata  in  CHANNEL_BITS*3  memory read data; synchronous, valid the cycle after the address.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE.
  - waddr=0, skid buffer empty.
  - load_ready, load_busy, load_done, rd_valid, mem_we = 0.
  - rd_val = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE, LOAD, DONE.
  - IDLE --load_start--> LOAD (waddr cleared to 0, skid buffer cleared).
  - LOAD --write of address 2**ADDR_BITS-1 committed--> DONE.
  - DONE --next cycle--> IDLE. load_done=1 only in DONE.
  - load_start while in LOAD restarts: waddr=0, skid buffer flushed, any pending write dropped.
  - load_start in DONE is honoured, same as from IDLE.
- Loader handshake:
  - A byte transfers when load_valid && load_ready.
  - load_ready = (state==LOAD) && skid buffer empty (registered).
  - Each accepted byte enters a 1-entry skid buffer.
- Port arbitration (combinational, each cycle):
  - rd_req=1: render grant.
    - mem_addr={side,col,row}, mem_we=0.
    - Buffered write waits; waddr and buffer hold.
  - rd_req=0 and buffer full: write grant.
    - mem_addr=waddr, mem_we=1, mem_wdata=buffer.
    - Buffer empties; waddr increments.
  - Otherwise: mem_we=0, mem_addr holds last value.
- Read latency: 1 cycle.
  - rd_valid = registered rd_req.
  - rd_val = mem_rdata during rd_valid, else holds its previous value.
  - Reads are served in every state, including during LOAD. Data at an address not yet written is whatever the memory contains.
- Wrap/bounds: waddr is ADDR_BITS wide and is never written past the last address. Transition to DONE happens on that final write; waddr does not wrap to 0.
- Throughput: 1 byte per 2 cycles max (buffer refill after write), and only while rd_req=0.
- Starvation: continuous rd_req stalls loading indefinitely. This is by design; the renderer idles in blanking.
- Reset mid-LOAD: load aborted, memory contents left partially written, no load_done.

Optional Feature:
- Macro: TEXTURE_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum[7:0], an 8-bit modulo-256 sum of all full load_data bytes accepted since the last load_start.
  - Cleared by reset and by load_start.
  - Stable from the load_done cycle onward.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold reset_n=0 mid-clock, asynchronously -> all outputs 0, state IDLE. Release, then load_valid=1 without load_start -> load_ready stays 0, no mem_we.
- Full load, rd_req=0, bytes = address[7:0] -> 8192 writes, mem_addr 0..8191 in order, mem_wdata = byte & 6'h3F. load_done pulses exactly once, 1 cycle after the final write. load_busy falls with load_done.
- Render priority: in LOAD with buffer full, hold rd_req=1 for 10 cycles at {1,6'd5,6'd9}.
  - mem_we=0, mem_addr=13'h1149 throughout.
  - rd_valid=1 for 10 cycles, starting 1 cycle after the first rd_req.
  - Write of the held waddr occurs on the first cycle after rd_req drops.
- Read data: after load, read {0,6'd2,6'd3} (addr 131) -> rd_valid next cycle, rd_val = 131 & 6'h3F = 6'h03.
- Restart: load_start after 100 bytes -> next write goes to address 0 with the newly supplied byte; the old buffered byte is never written.
- TEXTURE_LOAD_CHECKSUM_EN: load 8192 bytes of 8'hFF -> load_checksum = 8'h00. Load all 8'h01 -> 8'h00. Load byte 8'h03 at address 0 and zero elsewhere -> 8'h03.
